dmem_mmio_responder: RTL and testbench
======================================

Name: dmem_mmio_responder

Overview:
- Responder end of the processor's data-memory interface. It receives address_dmem, data and wren from the core and returns q_dmem.
- Decodes each access into one of two regions:
  - a word-addressed data RAM;
  - a small memory-mapped I/O register bank for the game: cycle counter, button capture, score/LED outputs, frame tick.
- Sits in the wrapper between the processor and board I/O, in place of a plain RAM.

Parameters:
- ADDR_BITS, 12, log2 of RAM depth in words (RAM = 2^ADDR_BITS x 32).
- MMIO_BASE, 32'h0000_1000, first word address of the MMIO bank.
- TICK_DIV, 833333, clock cycles per frame tick (≥2).
- NUM_BTN, 4, number of button inputs (≤32).

Ports:
- clock  in  1  master clock, all state on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- address_dmem  in  32  word address from processor.
- data  in  32  store data from processor.
- wren  in  1  store enable (1 = write this cycle).
- q_dmem  out  32  registered read data.
- btn_in  in  NUM_BTN  asynchronous raw button levels, active-high.
- score_out  out  32  SCORE register contents.
- led_out  out  8  LED register contents.
- tick_out  out  1  one-cycle pulse per frame.

Behaviour:
- Reset (reset==0 at a rising edge):
  - q_dmem, score_out, led_out, tick_out, all counters, synchronisers and edge flags go to 0.
  - RAM contents are not cleared.
  - wren is ignored while reset==0.
- Region decode:
  - address_dmem ≥ MMIO_BASE is MMIO, at offset = address_dmem - MMIO_BASE.
  - Otherwise it is RAM, indexed by address_dmem[ADDR_BITS-1:0]. Addresses between 2^ADDR_BITS and MMIO_BASE alias.
- Read latency is 1 cycle. q_dmem at edge N+1 holds the data for the address presented before edge N+1. Read happens every cycle regardless of wren.
- RAM read-during-write to the same word returns the old data (read-first). The new data is visible on the next access.
- MMIO map (word offsets):
  - 0 CYCLE, RO: free-running 32-bit counter, +1 per clock; wraps FFFF_FFFF→0.
  - 1 BTN_LEVEL, RO: synchronised levels in bits [NUM_BTN-1:0], upper bits 0.
  - 2 BTN_EDGE, RO: sticky rising-edge flags. A read returns the flags and clears them on the same edge. An edge detected in the same cycle as a clearing read survives (set wins).
  - 3 SCORE, RW: 32-bit.
  - 4 LED, RW: bits [7:0] stored, upper write bits dropped; reads zero-extended.
  - 5 TICK_COUNT, RO: frames elapsed, 32-bit, wraps. Any write clears it to 0. A write coinciding with a tick leaves 0 (clear wins).
  - Other offsets: read 0, writes ignored, no error.
- Writes to RO registers other than TICK_COUNT are ignored. CYCLE reads return the value before that edge's increment.
- Button path:
  - 2-flop synchroniser per bit.
  - Edge = synced & ~synced_prev.
  - Latency from btn_in change to BTN_LEVEL visible: 2 cycles.
- Tick divider:
  - Counts 0..TICK_DIV-1 then wraps.
  - tick_out=1 for exactly the cycle after the count equals TICK_DIV-1, registered.
  - TICK_COUNT increments on that same edge.
- No backpressure and no stalls: every cycle is an accepted access.

Decomposition:
- Shared package:
  - MMIO offset constants (OFF_CYCLE=0 … OFF_TICKCNT=5);
  - LED_WIDTH=8;
  - default MMIO_BASE.
- One sub-module, btn_sync_edge (NUM_BTN). Contains the synchroniser, previous-level register and sticky flags, with a clear input and level/edge outputs.
- RAM is an inferred array inside the top module.

Test Plan:
- Write 32'hDEAD_BEEF to address 5, then read address 5 next cycle → q_dmem=DEAD_BEEF one cycle after the read. Read 5 in the same cycle as a write of 1 → old value returned.
- Write 7 to MMIO_BASE+3 and 32'h1FF to MMIO_BASE+4 → score_out=7, led_out=8'hFF. Read MMIO_BASE+4 → 32'h0000_00FF.
- Pulse btn_in[2] high for 3 cycles:
  - BTN_LEVEL bit2=1 two cycles after rise;
  - first read of MMIO_BASE+2 → 32'h4, second read → 0.
  - Repeat with the edge landing on the read cycle → flag still set afterward.
- TICK_DIV=4, run 13 cycles from reset → tick_out pulses at cycles 4, 8, 12 and TICK_COUNT=3. Write MMIO_BASE+5 on the cycle a tick occurs → TICK_COUNT=0.
- Assert reset low mid-stream with wren=1 → write is discarded, all outputs 0. After release, CYCLE reads restart from 0.
- Read MMIO_BASE+9 → 0. Write 5 to address 4096+5 with MMIO_BASE=8192 → aliases RAM word 5.

Source files
------------

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared constants for the data-memory / MMIO responder: MMIO word offsets,
// LED register width and the default base address of the MMIO bank.
package dmem_mmio_responder_pkg;

   localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h0000_1000;
   localparam int          LED_WIDTH         = 8;

   localparam logic [31:0] OFF_CYCLE   = 32'd0;
   localparam logic [31:0] OFF_BTNLVL  = 32'd1;
   localparam logic [31:0] OFF_BTNEDGE = 32'd2;
   localparam logic [31:0] OFF_SCORE   = 32'd3;
   localparam logic [31:0] OFF_LED     = 32'd4;
   localparam logic [31:0] OFF_TICKCNT = 32'd5;

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// Processor data-memory bus between the core (master) and the responder (slave).
interface dmem_mmio_responder_if;

   // No valid/ready: every cycle is an accepted access. The master presents
   // address_dmem/data/wren before an edge; q_dmem after that edge carries the
   // read data for that address, and the store (if wren) has taken effect.
   logic [31:0] address_dmem;
   logic [31:0] data;
   logic        wren;
   logic [31:0] q_dmem;

   modport master (output address_dmem, output data, output wren, input q_dmem);
   modport slave  (input address_dmem, input data, input wren, output q_dmem);

endinterface

// File: rtl/btn_sync_edge.sv
// Per-bit two-flop button synchroniser with rising-edge detection and sticky
// edge flags that a clear pulse drops unless a new edge arrives in the same cycle.
module btn_sync_edge #(
   parameter int NUM_BTN = 4
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic [NUM_BTN-1:0] btn_i,
   input  logic               clr_i,
   output logic [NUM_BTN-1:0] level_o,
   output logic [NUM_BTN-1:0] edge_o
);

   logic [NUM_BTN-1:0] sync1_q, sync2_q, prev_q, flags_q;
   logic [NUM_BTN-1:0] rise, flags_d;

   always_comb begin
      rise    = sync2_q & ~prev_q;
      flags_d = (flags_q & ~{NUM_BTN{clr_i}}) | rise;
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         sync1_q <= '0;
         sync2_q <= '0;
         prev_q  <= '0;
         flags_q <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         prev_q  <= sync2_q;
         flags_q <= flags_d;
      end
   end

   assign level_o = sync2_q;
   assign edge_o  = flags_q;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder: word RAM below MMIO_BASE, game I/O register bank at
// and above it. One-cycle registered read every cycle, read-first on RAM.
module dmem_mmio_responder
   import dmem_mmio_responder_pkg::*;
#(
   parameter int          ADDR_BITS = 12,
   parameter logic [31:0] MMIO_BASE = DEFAULT_MMIO_BASE,
   parameter int          TICK_DIV  = 833333,
   parameter int          NUM_BTN   = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   dmem_mmio_responder_if.slave bus,
   input  logic [NUM_BTN-1:0]   btn_in,
   output logic [31:0]          score_out,
   output logic [LED_WIDTH-1:0] led_out,
   output logic                 tick_out
);

   localparam int                DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(TICK_DIV - 1);

   logic [31:0] mem [2**ADDR_BITS];

   logic [31:0]          q_dmem_q, rdata_d;
   logic [31:0]          cycle_q;
   logic [31:0]          score_q, score_d;
   logic [LED_WIDTH-1:0] led_q, led_d;
   logic [31:0]          tick_cnt_q, tick_cnt_d;
   logic [DIV_W-1:0]     div_q, div_d;
   logic                 tick_q, tick_d;

   logic                 is_mmio, mmio_wr, ram_wr, btn_clr, div_wrap;
   logic [31:0]          offset;
   logic [ADDR_BITS-1:0] ram_idx;
   logic [NUM_BTN-1:0]   btn_level, btn_edge;

   always_comb begin
      is_mmio  = (bus.address_dmem >= MMIO_BASE);
      offset   = bus.address_dmem - MMIO_BASE;
      ram_idx  = bus.address_dmem[ADDR_BITS-1:0];
      mmio_wr  = reset & bus.wren & is_mmio;
      ram_wr   = reset & bus.wren & ~is_mmio;
      // Any access to BTN_EDGE is a read, so it always clears the flags.
      btn_clr  = is_mmio & (offset == OFF_BTNEDGE);
      div_wrap = (div_q == DIV_LAST);
   end

   btn_sync_edge #(.NUM_BTN(NUM_BTN)) u_btn (
      .clk_i   (clock),
      .rst_ni  (reset),
      .btn_i   (btn_in),
      .clr_i   (btn_clr),
      .level_o (btn_level),
      .edge_o  (btn_edge)
   );

   always_comb begin
      rdata_d = '0;
      if (is_mmio) begin
         case (offset)
            OFF_CYCLE:   rdata_d = cycle_q;
            OFF_BTNLVL:  rdata_d = 32'(btn_level);
            OFF_BTNEDGE: rdata_d = 32'(btn_edge);
            OFF_SCORE:   rdata_d = score_q;
            OFF_LED:     rdata_d = 32'(led_q);
            OFF_TICKCNT: rdata_d = tick_cnt_q;
            default:     rdata_d = '0;
         endcase
      end else begin
         rdata_d = mem[ram_idx];
      end
   end

   always_comb begin
      score_d    = score_q;
      led_d      = led_q;
      tick_cnt_d = tick_cnt_q;
      div_d      = div_wrap ? '0 : div_q + 1'b1;
      tick_d     = div_wrap;
      if (mmio_wr && offset == OFF_SCORE) score_d = bus.data;
      if (mmio_wr && offset == OFF_LED)   led_d   = bus.data[LED_WIDTH-1:0];
      // A clearing write beats a simultaneous frame tick.
      if (mmio_wr && offset == OFF_TICKCNT) tick_cnt_d = '0;
      else if (div_wrap)                    tick_cnt_d = tick_cnt_q + 32'd1;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         q_dmem_q   <= '0;
         cycle_q    <= '0;
         score_q    <= '0;
         led_q      <= '0;
         tick_cnt_q <= '0;
         div_q      <= '0;
         tick_q     <= 1'b0;
      end else begin
         q_dmem_q   <= rdata_d;
         cycle_q    <= cycle_q + 32'd1;
         score_q    <= score_d;
         led_q      <= led_d;
         tick_cnt_q <= tick_cnt_d;
         div_q      <= div_d;
         tick_q     <= tick_d;
      end
   end

   always_ff @(posedge clock) begin
      if (ram_wr) mem[ram_idx] <= bus.data;
   end

   assign bus.q_dmem = q_dmem_q;
   assign score_out  = score_q;
   assign led_out    = led_q;
   assign tick_out   = tick_q;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed bench for dmem_mmio_responder: RAM, MMIO registers, buttons,
// frame tick and mid-stream reset, each checked against hand-computed values.
module tb_dmem_mmio_responder;

   localparam int          ADDR_BITS = 12;
   localparam logic [31:0] MMIO_BASE = 32'h0000_2000;
   localparam int          TICK_DIV  = 4;
   localparam int          NUM_BTN   = 4;

   logic               clock;
   logic               reset;
   logic [NUM_BTN-1:0] btn_in;
   logic [31:0]        score_out;
   logic [7:0]         led_out;
   logic               tick_out;

   int checks;
   int failures;

   dmem_mmio_responder_if bus ();

   dmem_mmio_responder #(
      .ADDR_BITS (ADDR_BITS),
      .MMIO_BASE (MMIO_BASE),
      .TICK_DIV  (TICK_DIV),
      .NUM_BTN   (NUM_BTN)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus.slave),
      .btn_in    (btn_in),
      .score_out (score_out),
      .led_out   (led_out),
      .tick_out  (tick_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Outputs are sampled 1 time unit after the rising edge.
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic drive(input logic [31:0] addr, input logic [31:0] wdata, input logic we);
      bus.address_dmem = addr;
      bus.data         = wdata;
      bus.wren         = we;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      cyc();
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL reset_q got=%h exp=%h", bus.q_dmem, 32'h0); end
      checks++; if (score_out !== 32'h0) begin failures++; $display("FAIL reset_score got=%h exp=%h", score_out, 32'h0); end
      checks++; if (led_out !== 8'h0) begin failures++; $display("FAIL reset_led got=%h exp=%h", led_out, 8'h0); end
      checks++; if (tick_out !== 1'b0) begin failures++; $display("FAIL reset_tick got=%b exp=0", tick_out); end
      reset = 1'b1;
   endtask

   task automatic test_ram();
      drive(32'd5, 32'hDEAD_BEEF, 1'b1); cyc();
      drive(32'd5, 32'h0, 1'b0);         cyc();
      checks++; if (bus.q_dmem !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read got=%h exp=%h", bus.q_dmem, 32'hDEAD_BEEF); end
      drive(32'd5, 32'h1, 1'b1);         cyc();
      checks++; if (bus.q_dmem !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ram_read_first got=%h exp=%h", bus.q_dmem, 32'hDEAD_BEEF); end
      drive(32'd5, 32'h0, 1'b0);         cyc();
      checks++; if (bus.q_dmem !== 32'h1) begin failures++; $display("FAIL ram_new_data got=%h exp=%h", bus.q_dmem, 32'h1); end
      drive(32'd10, 32'h0000_1234, 1'b1); cyc();
      drive(32'd6, 32'h0, 1'b0);          cyc();
      drive(32'd10, 32'h0, 1'b0);         cyc();
      checks++; if (bus.q_dmem !== 32'h0000_1234) begin failures++; $display("FAIL ram_word10 got=%h exp=%h", bus.q_dmem, 32'h0000_1234); end
   endtask

   task automatic test_mmio_rw();
      drive(MMIO_BASE + 32'd3, 32'd7, 1'b1);      cyc();
      drive(MMIO_BASE + 32'd4, 32'h1FF, 1'b1);    cyc();
      checks++; if (score_out !== 32'd7) begin failures++; $display("FAIL score_out got=%h exp=%h", score_out, 32'd7); end
      checks++; if (led_out !== 8'hFF) begin failures++; $display("FAIL led_out got=%h exp=%h", led_out, 8'hFF); end
      drive(MMIO_BASE + 32'd4, 32'h0, 1'b0);      cyc();
      checks++; if (bus.q_dmem !== 32'h0000_00FF) begin failures++; $display("FAIL led_read got=%h exp=%h", bus.q_dmem, 32'h0000_00FF); end
      drive(MMIO_BASE + 32'd3, 32'h0, 1'b0);      cyc();
      checks++; if (bus.q_dmem !== 32'd7) begin failures++; $display("FAIL score_read got=%h exp=%h", bus.q_dmem, 32'd7); end
      drive(MMIO_BASE + 32'd9, 32'hFFFF_FFFF, 1'b1); cyc();
      drive(MMIO_BASE + 32'd9, 32'h0, 1'b0);      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL unmapped_read got=%h exp=%h", bus.q_dmem, 32'h0); end
      checks++; if (score_out !== 32'd7) begin failures++; $display("FAIL unmapped_write_score got=%h exp=%h", score_out, 32'd7); end
      drive(MMIO_BASE + 32'd1, 32'hFFFF_FFFF, 1'b1); cyc();
      drive(MMIO_BASE + 32'd1, 32'h0, 1'b0);      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL ro_btnlvl_write got=%h exp=%h", bus.q_dmem, 32'h0); end
   endtask

   task automatic test_buttons();
      btn_in = 4'b0100;
      drive(MMIO_BASE + 32'd1, 32'h0, 1'b0);
      cyc();
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL btn_level_early got=%h exp=%h", bus.q_dmem, 32'h0); end
      cyc();
      checks++; if (bus.q_dmem !== 32'h4) begin failures++; $display("FAIL btn_level got=%h exp=%h", bus.q_dmem, 32'h4); end
      btn_in = 4'b0000;
      drive(MMIO_BASE + 32'd2, 32'h0, 1'b0);
      cyc();
      checks++; if (bus.q_dmem !== 32'h4) begin failures++; $display("FAIL btn_edge_first got=%h exp=%h", bus.q_dmem, 32'h4); end
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL btn_edge_second got=%h exp=%h", bus.q_dmem, 32'h0); end
      drive(MMIO_BASE + 32'd1, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) cyc();
      // Second pass: the rising edge is detected in the same cycle as a clearing read.
      btn_in = 4'b0100;
      cyc();
      cyc();
      drive(MMIO_BASE + 32'd2, 32'h0, 1'b0);
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL btn_edge_race_read got=%h exp=%h", bus.q_dmem, 32'h0); end
      cyc();
      checks++; if (bus.q_dmem !== 32'h4) begin failures++; $display("FAIL btn_edge_survives got=%h exp=%h", bus.q_dmem, 32'h4); end
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL btn_edge_cleared got=%h exp=%h", bus.q_dmem, 32'h0); end
      btn_in = 4'b0000;
      drive(MMIO_BASE + 32'd1, 32'h0, 1'b0);
      for (int i = 0; i < 4; i++) cyc();
   endtask

   task automatic test_alias();
      drive(32'd4096 + 32'd5, 32'd5, 1'b1); cyc();
      drive(32'd5, 32'h0, 1'b0);            cyc();
      checks++; if (bus.q_dmem !== 32'd5) begin failures++; $display("FAIL alias_word5 got=%h exp=%h", bus.q_dmem, 32'd5); end
      drive(32'd4096 + 32'd10, 32'h0, 1'b0); cyc();
      checks++; if (bus.q_dmem !== 32'h0000_1234) begin failures++; $display("FAIL alias_word10 got=%h exp=%h", bus.q_dmem, 32'h0000_1234); end
   endtask

   task automatic test_mid_reset();
      reset = 1'b0;
      drive(32'd10, 32'hFFFF_FFFF, 1'b1);
      cyc();
      cyc();
      checks++; if (bus.q_dmem !== 32'h0) begin failures++; $display("FAIL midrst_q got=%h exp=%h", bus.q_dmem, 32'h0); end
      checks++; if (score_out !== 32'h0) begin failures++; $display("FAIL midrst_score got=%h exp=%h", score_out, 32'h0); end
      checks++; if (led_out !== 8'h0) begin failures++; $display("FAIL midrst_led got=%h exp=%h", led_out, 8'h0); end
      checks++; if (tick_out !== 1'b0) begin failures++; $display("FAIL midrst_tick got=%b exp=0", tick_out); end
      reset = 1'b1;
      drive(MMIO_BASE + 32'd0, 32'h0, 1'b0);
      cyc();
      checks++; if (bus.q_dmem !== 32'd0) begin failures++; $display("FAIL cycle_restart0 got=%h exp=%h", bus.q_dmem, 32'd0); end
      cyc();
      checks++; if (bus.q_dmem !== 32'd1) begin failures++; $display("FAIL cycle_restart1 got=%h exp=%h", bus.q_dmem, 32'd1); end
      drive(32'd10, 32'h0, 1'b0);
      cyc();
      checks++; if (bus.q_dmem !== 32'h0000_1234) begin failures++; $display("FAIL midrst_write_dropped got=%h exp=%h", bus.q_dmem, 32'h0000_1234); end
   endtask

   task automatic test_tick();
      logic exp_tick;
      reset = 1'b0;
      drive(MMIO_BASE + 32'd5, 32'h0, 1'b0);
      cyc();
      cyc();
      reset = 1'b1;
      for (int i = 1; i <= 13; i++) begin
         cyc();
         exp_tick = ((i % TICK_DIV) == 0);
         checks++; if (tick_out !== exp_tick) begin failures++; $display("FAIL tick_cycle%0d got=%b exp=%b", i, tick_out, exp_tick); end
      end
      checks++; if (bus.q_dmem !== 32'd3) begin failures++; $display("FAIL tick_count got=%h exp=%h", bus.q_dmem, 32'd3); end
      cyc();
      cyc();
      drive(MMIO_BASE + 32'd5, 32'h0, 1'b1);
      cyc();
      checks++; if (tick_out !== 1'b1) begin failures++; $display("FAIL tick_cycle16 got=%b exp=1", tick_out); end
      drive(MMIO_BASE + 32'd5, 32'h0, 1'b0);
      cyc();
      checks++; if (bus.q_dmem !== 32'd0) begin failures++; $display("FAIL tick_clear_wins got=%h exp=%h", bus.q_dmem, 32'd0); end
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b0;
      btn_in   = '0;
      drive(32'h0, 32'h0, 1'b0);
      test_reset();
      test_ram();
      test_mmio_rw();
      test_buttons();
      test_alias();
      test_mid_reset();
      test_tick();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
